// File: rtl/elastic_operand_join_if.sv
// Operand-join port bundle: two SELF-protocol operand inputs, the joined
// ALU-side token and per-operand occupancy.
// master = producer/consumer side (neighbour PEs + ALU), slave = the join block.
interface elastic_operand_join_if #(
   parameter int DATA_WIDTH = 32,
   parameter int FIFO_DEPTH = 2
);
   localparam int OCC_W = $clog2(FIFO_DEPTH + 1);

   logic [DATA_WIDTH-1:0] in1_data;
   logic                  in1_valid;
   logic                  in1_stop;
   logic [DATA_WIDTH-1:0] in2_data;
   logic                  in2_valid;
   logic                  in2_stop;
   logic                  use_input_2;
   logic [DATA_WIDTH-1:0] output_data_1;
   logic [DATA_WIDTH-1:0] output_data_2;
   logic                  valid_output;
   logic                  stop_output;
   logic [OCC_W-1:0]      occupancy_1;
   logic [OCC_W-1:0]      occupancy_2;

   modport master (
      output in1_data, in1_valid, in2_data, in2_valid, use_input_2, stop_output,
      input  in1_stop, in2_stop, output_data_1, output_data_2, valid_output,
             occupancy_1, occupancy_2
   );

   modport slave (
      input  in1_data, in1_valid, in2_data, in2_valid, use_input_2, stop_output,
      output in1_stop, in2_stop, output_data_1, output_data_2, valid_output,
             occupancy_1, occupancy_2
   );
endinterface

// File: rtl/elastic_operand_join.sv
// elastic_operand_join: two independent operand FIFOs whose heads are joined
// into one (data_1, data_2, valid) token for the elastic ALU input port.
// Back-pressure (in*_stop) is a flop, never a combinational function of
// stop_output. Index 0 is operand 1, index 1 is operand 2 throughout.
// Optional feature macro: ELASTIC_JOIN_BYPASS_EN -- when defined, an operand
// arriving at an empty FIFO is presented as its head in the same cycle.
module elastic_operand_join #(
   parameter int DATA_WIDTH = 32,
   parameter int FIFO_DEPTH = 2
) (
   input logic                   clk,
   input logic                   reset_n,
   elastic_operand_join_if.slave bus
);

   localparam int PTR_W = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
   localparam int OCC_W = $clog2(FIFO_DEPTH + 1);
   localparam logic [OCC_W-1:0]      FULL_COUNT = OCC_W'(FIFO_DEPTH);
   localparam logic [OCC_W-1:0]      ZERO_COUNT = {OCC_W{1'b0}};
   localparam logic [OCC_W-1:0]      ONE_COUNT  = OCC_W'(1);
   localparam logic [PTR_W-1:0]      ZERO_PTR   = {PTR_W{1'b0}};
   localparam logic [PTR_W-1:0]      ONE_PTR    = PTR_W'(1);
   localparam logic [DATA_WIDTH-1:0] ZERO_DATA  = {DATA_WIDTH{1'b0}};

   // storage and pointers per operand
   logic [DATA_WIDTH-1:0] mem_r [2][FIFO_DEPTH];
   logic [PTR_W-1:0]      wr_ptr_r [2];
   logic [PTR_W-1:0]      rd_ptr_r [2];
   logic [OCC_W-1:0]      count_r [2];
   logic [1:0]            stop_r;

   // per-cycle decode
   logic [DATA_WIDTH-1:0] in_data_s [2];
   logic [DATA_WIDTH-1:0] head_s [2];
   logic [OCC_W-1:0]      count_next_s [2];
   logic [1:0]            in_valid_s;
   logic [1:0]            bypass_s;
   logic [1:0]            avail_s;
   logic [1:0]            push_s;
   logic [1:0]            pop_s;
   logic [1:0]            wr_s;
   logic [1:0]            rd_s;
   logic                  valid_s;
   logic                  fire_s;

   assign in_data_s[0] = bus.in1_data;
   assign in_data_s[1] = bus.in2_data;
   assign in_valid_s   = {bus.in2_valid, bus.in1_valid};

   // Head selection, join condition and per-FIFO write/read/count decode.
   always_comb begin
      bypass_s = 2'b00;
      avail_s  = 2'b00;
      push_s   = 2'b00;
      wr_s     = 2'b00;
      rd_s     = 2'b00;
      for (int i = 0; i < 2; i++) begin
         head_s[i]       = ZERO_DATA;
         count_next_s[i] = count_r[i];
      end

      for (int i = 0; i < 2; i++) begin
`ifdef ELASTIC_JOIN_BYPASS_EN
         bypass_s[i] = (count_r[i] == ZERO_COUNT) & in_valid_s[i] & ~stop_r[i];
`else
         bypass_s[i] = 1'b0;
`endif
         if (bypass_s[i]) begin
            head_s[i] = in_data_s[i];
         end else begin
            head_s[i] = mem_r[i][rd_ptr_r[i]];
         end
         avail_s[i] = (count_r[i] != ZERO_COUNT) | bypass_s[i];
         push_s[i]  = in_valid_s[i] & ~stop_r[i];
      end

      valid_s = avail_s[0] & (~bus.use_input_2 | avail_s[1]);
      fire_s  = valid_s & ~bus.stop_output;
      // operand 2 is only consumed when the op actually uses it
      pop_s   = {fire_s & bus.use_input_2, fire_s};

      for (int i = 0; i < 2; i++) begin
         // a bypassed operand consumed this cycle never touches the storage
         wr_s[i] = push_s[i] & ~(bypass_s[i] & pop_s[i]);
         rd_s[i] = pop_s[i] & ~bypass_s[i];
         case ({wr_s[i], rd_s[i]})
            2'b10:   count_next_s[i] = count_r[i] + ONE_COUNT;
            2'b01:   count_next_s[i] = count_r[i] - ONE_COUNT;
            default: count_next_s[i] = count_r[i];
         endcase
      end
   end

   // FIFO state update; stop is registered from the next count so a pop
   // releases it only on the following cycle.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         stop_r <= 2'b00;
         for (int i = 0; i < 2; i++) begin
            wr_ptr_r[i] <= ZERO_PTR;
            rd_ptr_r[i] <= ZERO_PTR;
            count_r[i]  <= ZERO_COUNT;
            for (int j = 0; j < FIFO_DEPTH; j++) begin
               mem_r[i][j] <= ZERO_DATA;
            end
         end
      end else begin
         for (int i = 0; i < 2; i++) begin
            if (wr_s[i]) begin
               mem_r[i][wr_ptr_r[i]] <= in_data_s[i];
               wr_ptr_r[i]           <= wr_ptr_r[i] + ONE_PTR;
            end
            if (rd_s[i]) begin
               rd_ptr_r[i] <= rd_ptr_r[i] + ONE_PTR;
            end
            count_r[i] <= count_next_s[i];
            stop_r[i]  <= (count_next_s[i] == FULL_COUNT);
         end
      end
   end

   assign bus.in1_stop      = stop_r[0];
   assign bus.in2_stop      = stop_r[1];
   assign bus.valid_output  = valid_s;
   assign bus.output_data_1 = head_s[0];
   assign bus.output_data_2 = bus.use_input_2 ? head_s[1] : ZERO_DATA;
   assign bus.occupancy_1   = count_r[0];
   assign bus.occupancy_2   = count_r[1];

endmodule

// File: tb/tb_elastic_operand_join.sv
// Directed bench for elastic_operand_join. Inputs change at the falling edge,
// outputs are sampled 1 time unit later, state commits on the rising edge.
module tb_elastic_operand_join;
   localparam int DW    = 32;
   localparam int DEPTH = 2;
`ifdef ELASTIC_JOIN_BYPASS_EN
   localparam int LAT = 0;
`else
   localparam int LAT = 1;
`endif

   logic clk = 1'b0;
   logic reset_n = 1'b0;
   int   checks = 0;
   int   fails  = 0;

   always #5 clk = ~clk;

   elastic_operand_join_if #(.DATA_WIDTH(DW), .FIFO_DEPTH(DEPTH)) bus ();

   elastic_operand_join #(.DATA_WIDTH(DW), .FIFO_DEPTH(DEPTH)) dut (
      .clk     (clk),
      .reset_n (reset_n),
      .bus     (bus)
   );

   task automatic drive(input logic v1, input int d1, input logic v2, input int d2);
      bus.in1_valid = v1;
      bus.in1_data  = d1;
      bus.in2_valid = v2;
      bus.in2_data  = d2;
   endtask

   task automatic test_reset();
      drive(1'b0, 0, 1'b0, 0);
      bus.use_input_2 = 1'b1;
      bus.stop_output = 1'b0;
      reset_n = 1'b0;
      @(negedge clk); #1;
      checks++;
      if ({bus.valid_output, bus.in1_stop, bus.in2_stop} !== 3'b000) begin
         fails++;
         $display("FAIL reset_ctl: got v/s1/s2=%b%b%b expected 000", bus.valid_output, bus.in1_stop, bus.in2_stop);
      end
      checks++;
      if (bus.output_data_1 !== 32'd0 || bus.output_data_2 !== 32'd0) begin
         fails++;
         $display("FAIL reset_data: got %0d,%0d expected 0,0", bus.output_data_1, bus.output_data_2);
      end
      checks++;
      if (bus.occupancy_1 !== 2'd0 || bus.occupancy_2 !== 2'd0) begin
         fails++;
         $display("FAIL reset_occ: got %0d,%0d expected 0,0", bus.occupancy_1, bus.occupancy_2);
      end
      @(negedge clk);
      reset_n = 1'b1;
      #1;
      checks++;
      if (bus.valid_output !== 1'b0) begin
         fails++;
         $display("FAIL reset_release_valid: got %b expected 0", bus.valid_output);
      end
   endtask

   // in1=5 at cycle 0, in2=7 at cycle 3 -> one token (5,7)
   task automatic test_join();
      logic exp_v;
      bus.use_input_2 = 1'b1;
      bus.stop_output = 1'b0;
      for (int c = 0; c < 6; c++) begin
         @(negedge clk);
         drive(c == 0, 5, c == 3, 7);
         #1;
         exp_v = (c == 3 + LAT);
         checks++;
         if (bus.valid_output !== exp_v) begin
            fails++;
            $display("FAIL join_valid c%0d: got %b expected %b", c, bus.valid_output, exp_v);
         end
         if (exp_v) begin
            checks++;
            if (bus.output_data_1 !== 32'd5 || bus.output_data_2 !== 32'd7) begin
               fails++;
               $display("FAIL join_data: got %0d,%0d expected 5,7", bus.output_data_1, bus.output_data_2);
            end
         end
         if (c == 2) begin
            checks++;
            if (bus.occupancy_1 !== 2'd1 || bus.occupancy_2 !== 2'd0) begin
               fails++;
               $display("FAIL join_occ_wait: got %0d,%0d expected 1,0", bus.occupancy_1, bus.occupancy_2);
            end
         end
         if (c == 5) begin
            checks++;
            if (bus.occupancy_1 !== 2'd0 || bus.occupancy_2 !== 2'd0) begin
               fails++;
               $display("FAIL join_occ_end: got %0d,%0d expected 0,0", bus.occupancy_1, bus.occupancy_2);
            end
         end
      end
   endtask

   // depth-2 fill with stop_output=1, third value held by the producer
   task automatic test_backpressure();
      bus.use_input_2 = 1'b0;
      bus.stop_output = 1'b1;
      @(negedge clk); drive(1'b1, 10, 1'b0, 0); #1;
      checks++;
      if (bus.in1_stop !== 1'b0) begin
         fails++;
         $display("FAIL bp_stop_a: got %b expected 0", bus.in1_stop);
      end
      @(negedge clk); drive(1'b1, 11, 1'b0, 0); #1;
      checks++;
      if (bus.in1_stop !== 1'b0 || bus.valid_output !== 1'b1 || bus.output_data_1 !== 32'd10 || bus.output_data_2 !== 32'd0) begin
         fails++;
         $display("FAIL bp_b: got stop=%b v=%b d=%0d,%0d expected 0 1 10,0", bus.in1_stop, bus.valid_output, bus.output_data_1, bus.output_data_2);
      end
      @(negedge clk); drive(1'b1, 12, 1'b0, 0); #1;
      checks++;
      if (bus.in1_stop !== 1'b1 || bus.output_data_1 !== 32'd10 || bus.occupancy_1 !== 2'd2) begin
         fails++;
         $display("FAIL bp_full: got stop=%b d=%0d occ=%0d expected 1 10 2", bus.in1_stop, bus.output_data_1, bus.occupancy_1);
      end
      @(negedge clk); bus.stop_output = 1'b0; #1;
      checks++;
      if (bus.in1_stop !== 1'b1 || bus.valid_output !== 1'b1 || bus.output_data_1 !== 32'd10) begin
         fails++;
         $display("FAIL bp_pop1: got stop=%b v=%b d=%0d expected 1 1 10", bus.in1_stop, bus.valid_output, bus.output_data_1);
      end
      @(negedge clk); #1;
      checks++;
      if (bus.in1_stop !== 1'b0 || bus.valid_output !== 1'b1 || bus.output_data_1 !== 32'd11) begin
         fails++;
         $display("FAIL bp_pop2: got stop=%b v=%b d=%0d expected 0 1 11", bus.in1_stop, bus.valid_output, bus.output_data_1);
      end
      @(negedge clk); drive(1'b0, 0, 1'b0, 0); #1;
      checks++;
      if (bus.valid_output !== 1'b1 || bus.output_data_1 !== 32'd12 || bus.occupancy_1 !== 2'd1) begin
         fails++;
         $display("FAIL bp_pop3: got v=%b d=%0d occ=%0d expected 1 12 1", bus.valid_output, bus.output_data_1, bus.occupancy_1);
      end
      @(negedge clk); #1;
      checks++;
      if (bus.valid_output !== 1'b0 || bus.occupancy_1 !== 2'd0) begin
         fails++;
         $display("FAIL bp_empty: got v=%b occ=%0d expected 0 0", bus.valid_output, bus.occupancy_1);
      end
   endtask

   // single-operand stream 1,2,3, operand 2 idle
   task automatic test_single_operand();
      int  k;
      logic exp_v;
      bus.use_input_2 = 1'b0;
      bus.stop_output = 1'b0;
      for (int c = 0; c < 5; c++) begin
         @(negedge clk);
         drive(c < 3, c + 1, 1'b0, 99);
         #1;
         k = c - LAT;
         exp_v = (k >= 0 && k < 3);
         checks++;
         if (bus.valid_output !== exp_v) begin
            fails++;
            $display("FAIL single_valid c%0d: got %b expected %b", c, bus.valid_output, exp_v);
         end
         if (exp_v) begin
            checks++;
            if (bus.output_data_1 !== 32'(k + 1)) begin
               fails++;
               $display("FAIL single_data c%0d: got %0d expected %0d", c, bus.output_data_1, k + 1);
            end
         end
         checks++;
         if (bus.output_data_2 !== 32'd0 || bus.occupancy_2 !== 2'd0) begin
            fails++;
            $display("FAIL single_op2 c%0d: got d2=%0d occ2=%0d expected 0 0", c, bus.output_data_2, bus.occupancy_2);
         end
      end
   endtask

   // both operands pushed as fast as allowed, stop_output toggling
   task automatic test_back_to_back();
      int n1 = 0;
      int n2 = 0;
      int exp_k = 0;
      bus.use_input_2 = 1'b1;
      for (int cyc = 0; cyc < 200 && exp_k < 20; cyc++) begin
         @(negedge clk);
         bus.stop_output = (cyc % 2 == 1);
         drive(n1 < 20, n1, n2 < 20, 100 + n2);
         #1;
         if (bus.valid_output === 1'b1) begin
            checks++;
            if (bus.output_data_1 !== 32'(exp_k) || bus.output_data_2 !== 32'(100 + exp_k)) begin
               fails++;
               $display("FAIL b2b_pair: got %0d,%0d expected %0d,%0d", bus.output_data_1, bus.output_data_2, exp_k, 100 + exp_k);
            end
            if (!bus.stop_output) exp_k++;
         end
         if (bus.in1_valid && !bus.in1_stop) n1++;
         if (bus.in2_valid && !bus.in2_stop) n2++;
      end
      @(negedge clk);
      drive(1'b0, 0, 1'b0, 0);
      bus.stop_output = 1'b0;
      #1;
      checks++;
      if (exp_k != 20) begin
         fails++;
         $display("FAIL b2b_count: got %0d tokens expected 20", exp_k);
      end
      checks++;
      if (bus.valid_output !== 1'b0 || bus.occupancy_1 !== 2'd0 || bus.occupancy_2 !== 2'd0) begin
         fails++;
         $display("FAIL b2b_drain: got v=%b occ=%0d,%0d expected 0 0,0", bus.valid_output, bus.occupancy_1, bus.occupancy_2);
      end
   endtask

   // asynchronous reset with two buffered tokens, then a fresh pair
   task automatic test_reset_midstream();
      bus.use_input_2 = 1'b1;
      bus.stop_output = 1'b1;
      @(negedge clk); drive(1'b1, 50, 1'b1, 60);
      @(negedge clk); drive(1'b1, 51, 1'b1, 61);
      @(negedge clk); drive(1'b0, 0, 1'b0, 0); #1;
      checks++;
      if (bus.occupancy_1 !== 2'd2 || bus.occupancy_2 !== 2'd2 || bus.output_data_1 !== 32'd50 || bus.output_data_2 !== 32'd60) begin
         fails++;
         $display("FAIL rst_pre: got occ=%0d,%0d d=%0d,%0d expected 2,2 50,60", bus.occupancy_1, bus.occupancy_2, bus.output_data_1, bus.output_data_2);
      end
      #1 reset_n = 1'b0;
      #1;
      checks++;
      if (bus.valid_output !== 1'b0 || bus.output_data_1 !== 32'd0 || bus.output_data_2 !== 32'd0) begin
         fails++;
         $display("FAIL rst_async_out: got v=%b d=%0d,%0d expected 0 0,0", bus.valid_output, bus.output_data_1, bus.output_data_2);
      end
      checks++;
      if (bus.occupancy_1 !== 2'd0 || bus.occupancy_2 !== 2'd0 || bus.in1_stop !== 1'b0 || bus.in2_stop !== 1'b0) begin
         fails++;
         $display("FAIL rst_async_state: got occ=%0d,%0d stop=%b%b expected 0,0 00", bus.occupancy_1, bus.occupancy_2, bus.in1_stop, bus.in2_stop);
      end
      @(negedge clk);
      reset_n = 1'b1;
      bus.stop_output = 1'b0;
      for (int c = 0; c < 3; c++) begin
         if (c > 0) @(negedge clk);
         drive(c == 0, 70, c == 0, 80);
         #1;
         checks++;
         if (bus.valid_output !== (c == LAT)) begin
            fails++;
            $display("FAIL rst_fresh_valid c%0d: got %b expected %b", c, bus.valid_output, (c == LAT));
         end
         if (c == LAT) begin
            checks++;
            if (bus.output_data_1 !== 32'd70 || bus.output_data_2 !== 32'd80) begin
               fails++;
               $display("FAIL rst_fresh_data: got %0d,%0d expected 70,80", bus.output_data_1, bus.output_data_2);
            end
         end
      end
      checks++;
      if (bus.occupancy_1 !== 2'd0 || bus.occupancy_2 !== 2'd0) begin
         fails++;
         $display("FAIL rst_fresh_occ: got %0d,%0d expected 0,0", bus.occupancy_1, bus.occupancy_2);
      end
   endtask

   // both operands arrive together at empty FIFOs
   task automatic test_bypass();
      bus.use_input_2 = 1'b1;
      bus.stop_output = 1'b0;
      @(negedge clk); drive(1'b1, 3, 1'b1, 4); #1;
      checks++;
`ifdef ELASTIC_JOIN_BYPASS_EN
      if (bus.valid_output !== 1'b1 || bus.output_data_1 !== 32'd3 || bus.output_data_2 !== 32'd4) begin
         fails++;
         $display("FAIL bypass_same: got v=%b d=%0d,%0d expected 1 3,4", bus.valid_output, bus.output_data_1, bus.output_data_2);
      end
`else
      if (bus.valid_output !== 1'b0) begin
         fails++;
         $display("FAIL bypass_same: got v=%b expected 0", bus.valid_output);
      end
`endif
      @(negedge clk); drive(1'b0, 0, 1'b0, 0); #1;
      checks++;
`ifdef ELASTIC_JOIN_BYPASS_EN
      if (bus.valid_output !== 1'b0 || bus.occupancy_1 !== 2'd0 || bus.occupancy_2 !== 2'd0) begin
         fails++;
         $display("FAIL bypass_next: got v=%b occ=%0d,%0d expected 0 0,0", bus.valid_output, bus.occupancy_1, bus.occupancy_2);
      end
`else
      if (bus.valid_output !== 1'b1 || bus.output_data_1 !== 32'd3 || bus.output_data_2 !== 32'd4) begin
         fails++;
         $display("FAIL bypass_next: got v=%b d=%0d,%0d expected 1 3,4", bus.valid_output, bus.output_data_1, bus.output_data_2);
      end
`endif
      @(negedge clk); #1;
      checks++;
      if (bus.valid_output !== 1'b0 || bus.occupancy_1 !== 2'd0 || bus.occupancy_2 !== 2'd0) begin
         fails++;
         $display("FAIL bypass_end: got v=%b occ=%0d,%0d expected 0 0,0", bus.valid_output, bus.occupancy_1, bus.occupancy_2);
      end
   endtask

   initial begin
      drive(1'b0, 0, 1'b0, 0);
      bus.use_input_2 = 1'b1;
      bus.stop_output = 1'b0;
      test_reset();
      test_join();
      test_backpressure();
      test_single_operand();
      test_back_to_back();
      test_reset_midstream();
      test_bypass();
      $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
      $finish;
   end
endmodule
